// File: rtl/ws2812_pkg.sv
// Shared types and timing helpers for the WS2812 serial LED driver.
package ws2812_pkg;

  // Driver sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    LOW,
    GAP,
    LATCH
  } state_t;

  // One colour word: 8 bits each of G, R, B as sent on the wire.
  localparam int w_color = 24;

  // Converts a duration in ns to clock cycles, rounded to nearest.
  function automatic int cycles(input int clk_mhz, input int ns);
    return (clk_mhz * ns + 500) / 1000;
  endfunction

  // Larger of two integers, used to size shared counters.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Single-bit WS2812 NRZ encoder. A start strobe launches one bit period:
// dout is high for T0H or T1H cycles (chosen by bit_val), then low until
// TBIT cycles have elapsed. high_done flags the last high cycle and done
// flags the last cycle of the bit, so a new start can follow without a gap.
module ws2812_bit_encoder #(
  parameter int T0H  = 11,
  parameter int T1H  = 22,
  parameter int TBIT = 34,
  parameter int CW   = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_val,
  output logic dout,
  output logic high_done,
  output logic done
);

  localparam logic [CW-1:0] T0H_C  = CW'(T0H);
  localparam logic [CW-1:0] T1H_C  = CW'(T1H);
  localparam logic [CW-1:0] TBIT_C = CW'(TBIT);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic          active_q, active_d;
  logic          bit_q, bit_d;
  logic          dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] th;

  // Bit timing: count cycles since start and shape the pulse.
  always_comb begin
    // NOTE: every signal written here gets a default first; a branch that
    // skipped one would otherwise infer a latch.
    active_d  = active_q;
    bit_d     = bit_q;
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    th        = bit_q ? T1H_C : T0H_C;
    high_done = active_q && (cnt_q == th - ONE_C);
    done      = active_q && (cnt_q == TBIT_C - ONE_C);

    if (active_q) begin
      cnt_d  = cnt_q + ONE_C;
      dout_d = (cnt_q + ONE_C) < th;
      if (done) begin
        active_d = 1'b0;
        dout_d   = 1'b0;
        cnt_d    = '0;
      end
    end

    // A start on the final cycle of a bit chains straight into the next one.
    if (start) begin
      active_d = 1'b1;
      bit_d    = bit_val;
      dout_d   = 1'b1;
      cnt_d    = '0;
    end
  end

  // Bit timing registers; dout is registered so the pin never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      bit_q    <= 1'b0;
      dout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values present before the edge.
      active_q <= active_d;
      bit_q    <= bit_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ws2812_led_driver.sv
// WS2812 strip driver. Accepts 24-bit colour words over valid/ready,
// serialises each MSB-first through ws2812_bit_encoder, then either waits
// in GAP for the next word of the frame or holds the line low for the
// latch interval after the last word. A GAP that lasts a full latch
// interval is treated as an implicit latch and returns to IDLE.
//
// Build option: define WS2812_RGB_INPUT_EN to accept in_data as {R,G,B};
// it is reordered to the wire order {G,R,B} at capture. Without it,
// in_data is already {G,R,B}.
module ws2812_led_driver
  import ws2812_pkg::*;
#(
  parameter int clk_mhz  = 27,
  parameter int t0h_ns   = 400,
  parameter int t1h_ns   = 800,
  parameter int bit_ns   = 1250,
  parameter int latch_us = 300
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [w_color-1:0] in_data,
  input  logic               in_last,
  output logic               busy,
  output logic               dout
);

  localparam int T0H    = cycles(clk_mhz, t0h_ns);
  localparam int T1H    = cycles(clk_mhz, t1h_ns);
  localparam int TBIT   = cycles(clk_mhz, bit_ns);
  localparam int TLATCH = clk_mhz * latch_us;
  localparam int CW     = $clog2(max2(TBIT, TLATCH) + 1);

  localparam logic [CW-1:0] TLATCH_M1 = CW'(TLATCH - 1);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  if (!(T0H > 0 && T0H < T1H && T1H < TBIT)) begin : g_bad_timing
    $error("ws2812_led_driver: timing must satisfy 0 < T0H < T1H < TBIT");
  end

  state_t             state_q, state_d;
  logic [w_color-1:0] shift_q, shift_d;
  logic [4:0]         idx_q, idx_d;
  logic               last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               take;
  logic               enc_start;
  logic               enc_bit;
  logic               enc_high_done;
  logic               enc_done;
  logic [w_color-1:0] cap_word;

  // Colour word in wire order (G,R,B) as it will be loaded into the shifter.
  always_comb begin
`ifdef WS2812_RGB_INPUT_EN
    cap_word = {in_data[15:8], in_data[23:16], in_data[7:0]};
`else
    cap_word = in_data;
`endif
  end

  // Ready only in the states that can start a word; forced low in reset.
  assign in_ready = rst_n && ((state_q == IDLE) || (state_q == GAP));
  assign take     = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  // Next-state logic: handshake, per-bit sequencing, GAP and LATCH timing.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    enc_start = 1'b0;
    enc_bit   = 1'b0;

    if (take) begin
      // From IDLE or GAP: load the word and launch its MSB immediately.
      state_d   = HIGH;
      shift_d   = cap_word;
      idx_d     = 5'd23;
      last_d    = in_last;
      cnt_d     = '0;
      enc_start = 1'b1;
      enc_bit   = cap_word[w_color-1];
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
        end
        HIGH: begin
          if (enc_high_done) state_d = LOW;
        end
        LOW: begin
          if (enc_done) begin
            if (idx_q != 5'd0) begin
              // Rotating instead of dropping the MSB keeps every bit in use;
              // the wrapped bit is never transmitted.
              shift_d   = {shift_q[w_color-2:0], shift_q[w_color-1]};
              idx_d     = idx_q - 5'd1;
              enc_start = 1'b1;
              enc_bit   = shift_q[w_color-2];
              state_d   = HIGH;
            end else if (last_q) begin
              state_d = LATCH;
              cnt_d   = '0;
            end else begin
              state_d = GAP;
              cnt_d   = '0;
            end
          end
        end
        GAP: begin
          if (cnt_q == TLATCH_M1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        LATCH: begin
          if (cnt_q == TLATCH_M1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sequencing registers; a reset mid-word discards the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  ws2812_bit_encoder #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT),
    .CW   (CW)
  ) u_bit_encoder (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (enc_start),
    .bit_val   (enc_bit),
    .dout      (dout),
    .high_done (enc_high_done),
    .done      (enc_done)
  );

endmodule

// File: tb/tb_ws2812_led_driver.sv
// Directed bench for ws2812_led_driver at the default 27 MHz timing
// (T0H=11, T1H=22, TBIT=34, TLATCH=8100). Outputs are sampled 1 ns after
// each rising edge; trace index k is the k-th cycle after a handshake edge.
module tb_ws2812_led_driver;

  localparam int T0H    = 11;
  localparam int T1H    = 22;
  localparam int TBIT   = 34;
  localparam int TLATCH = 8100;
  localparam int WORD   = 24 * TBIT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [23:0] in_data = 24'h0;
  logic        in_ready;
  logic        busy;
  logic        dout;

  int checks = 0;
  int failures = 0;

  bit tr_dout[$];
  bit tr_busy[$];
  bit tr_ready[$];
  int hi_q[$];
  int lo_q[$];
  int lead0;
  int accept_idx;

  ws2812_led_driver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .busy     (busy),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int hi_of(input bit b);
    return b ? T1H : T0H;
  endfunction

  // Present a word while the DUT is ready; returns at trace index 0.
  task automatic start_word(input logic [23:0] d, input logic l, input bit keep);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic capture(input int n, input int scramble_until, input bit drop_on_accept);
    bit pend;
    pend = 1'b0;
    tr_dout.delete();
    tr_busy.delete();
    tr_ready.delete();
    accept_idx = -1;
    for (int k = 0; k < n; k++) begin
      if (pend) begin
        in_valid = 1'b0;
        pend = 1'b0;
      end
      tr_dout.push_back(dout);
      tr_busy.push_back(busy);
      tr_ready.push_back(in_ready);
      if (drop_on_accept && accept_idx < 0 && in_valid && in_ready) begin
        accept_idx = k;
        pend = 1'b1;
      end
      if (k < scramble_until) begin
        in_data = 24'($urandom);
        in_last = 1'($urandom_range(0, 1));
      end else if (scramble_until > 0 && k == scramble_until) begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic decode_runs();
    int i;
    int n;
    i = 0;
    lead0 = 0;
    hi_q.delete();
    lo_q.delete();
    while (i < tr_dout.size() && tr_dout[i] == 1'b0) begin
      lead0++;
      i++;
    end
    while (i < tr_dout.size()) begin
      n = 0;
      while (i < tr_dout.size() && tr_dout[i] == 1'b1) begin n++; i++; end
      hi_q.push_back(n);
      n = 0;
      while (i < tr_dout.size() && tr_dout[i] == 1'b0) begin n++; i++; end
      lo_q.push_back(n);
    end
  endtask

  function automatic int first_idle();
    for (int k = 0; k < tr_busy.size(); k++)
      if (tr_busy[k] == 1'b0) return k;
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout !== 1'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0", dout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_word();
    logic [23:0] w;
    int n;
    w = 24'hFF0000;
    n = WORD + TLATCH + 10;
    start_word(w, 1'b1, 1'b0);
    capture(n, 0, 1'b0);
    decode_runs();
    checks++; if (lead0 !== 0) begin failures++; $display("FAIL single_latency lead_zeros=%0d exp=0", lead0); end
    checks++; if (hi_q.size() !== 24) begin failures++; $display("FAIL single_pulses got=%0d exp=24", hi_q.size()); end
    for (int i = 0; i < 24; i++) begin
      if (i < hi_q.size()) begin
        checks++;
        if (hi_q[i] !== hi_of(w[23-i])) begin
          failures++; $display("FAIL single_hi[%0d] got=%0d exp=%0d", i, hi_q[i], hi_of(w[23-i]));
        end
        if (i < 23) begin
          checks++;
          if (lo_q[i] !== TBIT - hi_of(w[23-i])) begin
            failures++; $display("FAIL single_lo[%0d] got=%0d exp=%0d", i, lo_q[i], TBIT - hi_of(w[23-i]));
          end
        end
      end
    end
    if (lo_q.size() == 24) begin
      checks++;
      if (lo_q[23] !== TBIT - T0H + TLATCH + 10) begin
        failures++; $display("FAIL single_tail_low got=%0d exp=%0d", lo_q[23], TBIT - T0H + TLATCH + 10);
      end
    end
    checks++; if (tr_ready[WORD+5] !== 1'b0) begin failures++; $display("FAIL single_latch_ready got=%b exp=0", tr_ready[WORD+5]); end
    checks++; if (first_idle() !== WORD + TLATCH) begin failures++; $display("FAIL single_idle_at got=%0d exp=%0d", first_idle(), WORD + TLATCH); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] w;
    int n;
    int e;
    w = {24'hA5A5A5, 24'h0F0F0F};
    n = 2 * WORD + 1 + TLATCH + 10;
    start_word(24'hA5A5A5, 1'b0, 1'b1);
    in_data = 24'h0F0F0F;
    in_last = 1'b1;
    capture(n, 0, 1'b1);
    decode_runs();
    checks++; if (accept_idx !== WORD) begin failures++; $display("FAIL b2b_accept_idx got=%0d exp=%0d", accept_idx, WORD); end
    checks++; if (hi_q.size() !== 48) begin failures++; $display("FAIL b2b_pulses got=%0d exp=48", hi_q.size()); end
    for (int i = 0; i < 48; i++) begin
      if (i < hi_q.size()) begin
        checks++;
        if (hi_q[i] !== hi_of(w[47-i])) begin
          failures++; $display("FAIL b2b_hi[%0d] got=%0d exp=%0d", i, hi_q[i], hi_of(w[47-i]));
        end
        if (i < 47) begin
          e = TBIT - hi_of(w[47-i]) + ((i == 23) ? 1 : 0);
          checks++;
          if (lo_q[i] !== e) begin failures++; $display("FAIL b2b_lo[%0d] got=%0d exp=%0d", i, lo_q[i], e); end
        end
      end
    end
    checks++; if (first_idle() !== 2 * WORD + 1 + TLATCH) begin failures++; $display("FAIL b2b_idle_at got=%0d exp=%0d", first_idle(), 2 * WORD + 1 + TLATCH); end
  endtask

  task automatic test_gap_expiry();
    int n;
    int bad_ready;
    n = WORD + TLATCH + 10;
    start_word(24'h00FF00, 1'b0, 1'b0);
    capture(n, 0, 1'b0);
    decode_runs();
    bad_ready = 0;
    for (int k = WORD; k < n; k++) if (tr_ready[k] != 1'b1) bad_ready++;
    checks++; if (hi_q.size() !== 24) begin failures++; $display("FAIL gap_pulses got=%0d exp=24", hi_q.size()); end
    checks++; if (bad_ready !== 0) begin failures++; $display("FAIL gap_ready_low_cycles got=%0d exp=0", bad_ready); end
    if (lo_q.size() == 24) begin
      checks++;
      if (lo_q[23] !== TBIT - T0H + TLATCH + 10) begin
        failures++; $display("FAIL gap_tail_low got=%0d exp=%0d", lo_q[23], TBIT - T0H + TLATCH + 10);
      end
    end
    checks++; if (first_idle() !== WORD + TLATCH) begin failures++; $display("FAIL gap_idle_at got=%0d exp=%0d", first_idle(), WORD + TLATCH); end
  endtask

  task automatic test_hold_during_word();
    logic [23:0] w;
    int n;
    int ready_hi;
    w = 24'h3C5A96;
    n = WORD + TLATCH + 10;
    start_word(w, 1'b1, 1'b1);
    capture(n, 800, 1'b0);
    decode_runs();
    ready_hi = 0;
    for (int k = 0; k < 800; k++) if (tr_ready[k] != 1'b0) ready_hi++;
    checks++; if (ready_hi !== 0) begin failures++; $display("FAIL hold_ready_high_cycles got=%0d exp=0", ready_hi); end
    checks++; if (hi_q.size() !== 24) begin failures++; $display("FAIL hold_pulses got=%0d exp=24", hi_q.size()); end
    for (int i = 0; i < 24; i++) begin
      if (i < hi_q.size()) begin
        checks++;
        if (hi_q[i] !== hi_of(w[23-i])) begin
          failures++; $display("FAIL hold_hi[%0d] got=%0d exp=%0d", i, hi_q[i], hi_of(w[23-i]));
        end
      end
    end
    checks++; if (tr_ready[WORD+5] !== 1'b0) begin failures++; $display("FAIL hold_latch_ready got=%b exp=0", tr_ready[WORD+5]); end
    checks++; if (first_idle() !== WORD + TLATCH) begin failures++; $display("FAIL hold_idle_at got=%0d exp=%0d", first_idle(), WORD + TLATCH); end
  endtask

  task automatic test_reset_mid_word();
    logic [23:0] w;
    start_word(24'hFFFFFF, 1'b1, 1'b0);
    repeat (10 * TBIT + 5) @(posedge clk);
    #1;
    checks++; if (dout !== 1'b1) begin failures++; $display("FAIL midrst_pre_dout got=%b exp=1", dout); end
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 1'b0) begin failures++; $display("FAIL midrst_dout got=%b exp=0", dout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", in_ready); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    w = 24'h000001;
    start_word(w, 1'b1, 1'b0);
    capture(WORD + TLATCH + 10, 0, 1'b0);
    decode_runs();
    checks++; if (lead0 !== 0) begin failures++; $display("FAIL midrst_latency lead_zeros=%0d exp=0", lead0); end
    checks++; if (hi_q.size() !== 24) begin failures++; $display("FAIL midrst_pulses got=%0d exp=24", hi_q.size()); end
    for (int i = 0; i < 24; i++) begin
      if (i < hi_q.size()) begin
        checks++;
        if (hi_q[i] !== hi_of(w[23-i])) begin
          failures++; $display("FAIL midrst_hi[%0d] got=%0d exp=%0d", i, hi_q[i], hi_of(w[23-i]));
        end
      end
    end
    checks++; if (first_idle() !== WORD + TLATCH) begin failures++; $display("FAIL midrst_idle_at got=%0d exp=%0d", first_idle(), WORD + TLATCH); end
  endtask

  task automatic test_color_order();
    logic [23:0] exp_w;
`ifdef WS2812_RGB_INPUT_EN
    exp_w = 24'h341256;
`else
    exp_w = 24'h123456;
`endif
    start_word(24'h123456, 1'b1, 1'b0);
    capture(WORD + 10, 0, 1'b0);
    decode_runs();
    checks++; if (hi_q.size() !== 24) begin failures++; $display("FAIL order_pulses got=%0d exp=24", hi_q.size()); end
    for (int i = 0; i < 24; i++) begin
      if (i < hi_q.size()) begin
        checks++;
        if (hi_q[i] !== hi_of(exp_w[23-i])) begin
          failures++; $display("FAIL order_hi[%0d] got=%0d exp=%0d", i, hi_q[i], hi_of(exp_w[23-i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap_expiry();
    test_hold_during_word();
    test_reset_mid_word();
    test_color_order();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
